// File: rtl/pc_unit.sv
// pc_unit: registered program counter with a hardware return-address stack.
//
// Sits between the control FSM and the instruction BRAM; pc drives the BRAM
// address directly, so it comes straight from a flop.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; overrides stall and op
//   stall        1 = hold pc, stack pointer, stack contents and stack_err
//   op           0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 behave as INC
//   cond         branch-taken qualifier (BRANCH only)
//   target       absolute target for JUMP / CALL
//   offset       two's-complement displacement for BRANCH
//   pc           current program counter
//   ret_addr     top-of-stack entry, 0 when the stack is empty
//   stack_full   stack holds STACK_DEPTH entries
//   stack_empty  stack holds no entries
//   stack_err    sticky overflow/underflow flag, cleared only by reset
module pc_unit #(
    parameter int               WIDTH        = 16,
    parameter int               STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic             cond,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ret_addr,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_INC    = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] ras [STACK_DEPTH];
    logic [WIDTH-1:0] pc_inc;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic             do_push;

    assign pc_inc      = pc + WIDTH'(1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    // sp points at the next free slot; the top entry lives one below it.
    // Both indices are only used when they are in range (guarded by the
    // full/empty decodes), so truncating to the array index width is safe.
    assign push_idx = IDX_W'(sp);
    assign top_idx  = IDX_W'(sp - SP_W'(1));

    assign ret_addr = stack_empty ? '0 : ras[top_idx];

    assign do_push = !reset && !stall && (op == OP_CALL) && !stack_full;

    // Stack storage carries no reset: stale entries are unreachable once sp
    // is cleared, because ret_addr and RET both gate on stack_empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            sp        <= '0;
            stack_err <= 1'b0;
        end else if (!stall) begin
            case (op)
                OP_JUMP: begin
                    pc <= target;
                end
                OP_BRANCH: begin
                    // Modulo add of the two's-complement offset is a signed add.
                    pc <= cond ? (pc + offset) : pc_inc;
                end
                OP_CALL: begin
                    if (stack_full) begin
                        pc        <= pc_inc;
                        stack_err <= 1'b1;
                    end else begin
                        pc <= target;
                        sp <= sp + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc        <= pc_inc;
                        stack_err <= 1'b1;
                    end else begin
                        pc <= ras[top_idx];
                        sp <= sp - SP_W'(1);
                    end
                end
                default: begin
                    pc <= pc_inc;
                end
            endcase
        end
    end

endmodule
